// File: rtl/tetris_pkg.sv
// Shared piece codes, FSM states and the 2x2 piece-shape lookup for the board pipeline.
// Shape bit order: [0] top-left, [1] top-right, [2] bottom-left, [3] bottom-right.
package tetris_pkg;

   typedef enum logic [1:0] {
      PIECE_SINGLE = 2'b00,
      PIECE_HPAIR  = 2'b01,
      PIECE_SQUARE = 2'b10,
      PIECE_L      = 2'b11
   } piece_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_SPAWN,
      ST_DONE
   } state_e;

   function automatic logic [3:0] piece_shape(input piece_e p);
      logic [3:0] shape;
      case (p)
         PIECE_SINGLE: shape = 4'b0001;
         PIECE_HPAIR:  shape = 4'b0011;
         PIECE_SQUARE: shape = 4'b1111;
         default:      shape = 4'b1101;
      endcase
      return shape;
   endfunction

endpackage

// File: rtl/spawn_mask_gen.sv
// Combinational spawn mask: places the piece's 2x2 shape in rows 0-1 starting at SPAWN_COL.
// Zero latency, no flow control; shared with the drop logic.
module spawn_mask_gen
   import tetris_pkg::*;
#(
   parameter int COLS      = 4,
   parameter int ROWS      = 8,
   parameter int SPAWN_COL = 1
) (
   input  logic [1:0]           i_piece,
   output logic [ROWS*COLS-1:0] o_mask
);

   logic [3:0] w_shape;

   assign w_shape = piece_shape(piece_e'(i_piece));

   always_comb begin
      o_mask                       = '0;
      o_mask[SPAWN_COL]            = w_shape[0];
      o_mask[SPAWN_COL+1]          = w_shape[1];
      o_mask[COLS+SPAWN_COL]       = w_shape[2];
      o_mask[COLS+SPAWN_COL+1]     = w_shape[3];
   end

endmodule

// File: rtl/line_clear_engine.sv
// Multi-cycle line clear: scans bottom-up compacting non-full rows, spawns the next piece, flags collision.
// Fixed ROWS+2 cycle latency from start to done; start is dropped while busy.
module line_clear_engine
   import tetris_pkg::*;
#(
   parameter int COLS      = 4,
   parameter int ROWS      = 8,
   parameter int SPAWN_COL = 1,
   parameter int TOTAL_W   = 16
) (
   input  logic                      clka,
   input  logic                      restart,
   input  logic                      start,
   input  logic [ROWS*COLS-1:0]      board_in,
   input  logic [1:0]                curr_piece,
   output logic                      busy,
   output logic                      done,
   output logic [ROWS*COLS-1:0]      board_out,
   output logic [$clog2(ROWS+1)-1:0] lines_cleared,
   output logic                      error,
   output logic                      game_over,
   output logic [TOTAL_W-1:0]        total_lines
);

   localparam int CW = $clog2(ROWS+1);
   localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SW = ((TOTAL_W > CW) ? TOTAL_W : CW) + 1;

   state_e                r_state;
   logic [ROWS*COLS-1:0]  r_src;
   logic [ROWS*COLS-1:0]  r_work;
   logic [PW-1:0]         r_rd_ptr;
   logic [PW-1:0]         r_wr_ptr;
   logic [CW-1:0]         r_cnt;
   logic [1:0]            r_piece;
   logic                  r_err;

   logic [ROWS*COLS-1:0]  w_mask;
   logic                  w_row_full;
   logic [SW-1:0]         w_sum;
   logic [TOTAL_W-1:0]    w_total_next;

   spawn_mask_gen #(
      .COLS      (COLS),
      .ROWS      (ROWS),
      .SPAWN_COL (SPAWN_COL)
   ) u_spawn_mask (
      .i_piece (r_piece),
      .o_mask  (w_mask)
   );

   assign w_row_full   = &r_src[r_rd_ptr*COLS +: COLS];
   assign w_sum        = SW'(total_lines) + SW'(r_cnt);
   assign w_total_next = (w_sum > SW'({TOTAL_W{1'b1}})) ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];

   always_ff @(posedge clka) begin
      if (restart) begin
         r_state       <= ST_IDLE;
         r_src         <= '0;
         r_work        <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_cnt         <= '0;
         r_piece       <= '0;
         r_err         <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         board_out     <= '0;
         lines_cleared <= '0;
         error         <= 1'b0;
         game_over     <= 1'b0;
         total_lines   <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_src    <= board_in;
                  r_piece  <= curr_piece;
                  r_work   <= '0;
                  r_rd_ptr <= PW'(ROWS-1);
                  r_wr_ptr <= PW'(ROWS-1);
                  r_cnt    <= '0;
                  busy     <= 1'b1;
                  r_state  <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // Write pointer only advances on survivors, so writes never go below row 0.
               if (w_row_full) begin
                  r_cnt <= r_cnt + CW'(1);
               end else begin
                  r_work[r_wr_ptr*COLS +: COLS] <= r_src[r_rd_ptr*COLS +: COLS];
                  r_wr_ptr                      <= r_wr_ptr - PW'(1);
               end
               if (r_rd_ptr == '0) begin
                  r_state <= ST_SPAWN;
               end else begin
                  r_rd_ptr <= r_rd_ptr - PW'(1);
               end
            end
            ST_SPAWN: begin
               r_err   <= |(w_mask & r_work);
               r_work  <= r_work | w_mask;
               r_state <= ST_DONE;
            end
            ST_DONE: begin
               board_out     <= r_work;
               lines_cleared <= r_cnt;
               error         <= r_err;
               game_over     <= game_over | r_err;
               total_lines   <= w_total_next;
               done          <= 1'b1;
               busy          <= 1'b0;
               r_state       <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: a reference model queues expectations at start, checked at done.
// A second instance with a 2-bit total runs in lockstep to exercise saturation.
module tb_line_clear_engine;

   localparam int COLS      = 4;
   localparam int ROWS      = 8;
   localparam int SPAWN_COL = 1;
   localparam int N         = COLS*ROWS;
   localparam int CW        = $clog2(ROWS+1);

   logic          clka = 1'b0;
   logic          restart;
   logic          start;
   logic [N-1:0]  board_in;
   logic [1:0]    curr_piece;

   logic          busy, done, error, game_over;
   logic [N-1:0]  board_out;
   logic [CW-1:0] lines_cleared;
   logic [15:0]   total_lines;

   logic          busy2, done2, error2, game_over2;
   logic [N-1:0]  board_out2;
   logic [CW-1:0] lines_cleared2;
   logic [1:0]    total_lines2;

   line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .SPAWN_COL(SPAWN_COL), .TOTAL_W(16)) dut (
      .clka(clka), .restart(restart), .start(start), .board_in(board_in), .curr_piece(curr_piece),
      .busy(busy), .done(done), .board_out(board_out), .lines_cleared(lines_cleared),
      .error(error), .game_over(game_over), .total_lines(total_lines)
   );

   line_clear_engine #(.COLS(COLS), .ROWS(ROWS), .SPAWN_COL(SPAWN_COL), .TOTAL_W(2)) dut_sat (
      .clka(clka), .restart(restart), .start(start), .board_in(board_in), .curr_piece(curr_piece),
      .busy(busy2), .done(done2), .board_out(board_out2), .lines_cleared(lines_cleared2),
      .error(error2), .game_over(game_over2), .total_lines(total_lines2)
   );

   always #5 clka = ~clka;

   typedef struct {
      logic [N-1:0] board;
      int           lines;
      logic         err;
      logic         gover;
      int           total;
      int           total2;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   int   done_cnt = 0;
   logic gover_m;
   int   total_m;
   int   total2_m;

   always @(posedge clka) cyc <= cyc + 1;
   always @(negedge clka) if (done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic void model(input logic [N-1:0] b, input logic [1:0] p,
                                 output logic [N-1:0] o, output int lines, output logic err);
      logic [N-1:0] m;
      int           w;
      o     = '0;
      lines = 0;
      w     = ROWS-1;
      for (int r = ROWS-1; r >= 0; r--) begin
         if (b[r*COLS +: COLS] == {COLS{1'b1}}) begin
            lines++;
         end else begin
            o[w*COLS +: COLS] = b[r*COLS +: COLS];
            w--;
         end
      end
      m = '0;
      m[SPAWN_COL]          = 1'b1;
      m[SPAWN_COL+1]        = (p == 2'b01) || (p == 2'b10);
      m[COLS+SPAWN_COL]     = (p == 2'b10) || (p == 2'b11);
      m[COLS+SPAWN_COL+1]   = (p == 2'b10) || (p == 2'b11);
      err = |(m & o);
      o   = o | m;
   endfunction

   task automatic issue(input logic [N-1:0] b, input logic [1:0] p, input bit push);
      exp_t e;
      if (push) begin
         model(b, p, e.board, e.lines, e.err);
         gover_m  = gover_m | e.err;
         total_m  = (total_m + e.lines > 65535) ? 65535 : total_m + e.lines;
         total2_m = (total2_m + e.lines > 3) ? 3 : total2_m + e.lines;
         e.gover  = gover_m;
         e.total  = total_m;
         e.total2 = total2_m;
         e.cyc    = cyc;
         sb.push_back(e);
      end
      board_in   = b;
      curr_piece = p;
      start      = 1'b1;
      @(negedge clka);
      start      = 1'b0;
      if (push) chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_done();
      exp_t e;
      int   n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clka);
         n++;
      end
      if (sb.size() == 0) begin
         chk("sb_underflow", 0, 1);
         return;
      end
      e = sb.pop_front();
      if (done !== 1'b1) begin
         chk("done_timeout", 0, 1);
         return;
      end
      chk("latency",       cyc - e.cyc - 1, ROWS+2);
      chk("board_out",     board_out,       e.board);
      chk("lines_cleared", lines_cleared,   e.lines);
      chk("error",         error,           e.err);
      chk("game_over",     game_over,       e.gover);
      chk("total_lines",   total_lines,     e.total);
      chk("done_sat",      done2,           1);
      chk("total_sat",     total_lines2,    e.total2);
      chk("busy_at_done",  busy,            0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  busy,          0);
      chk({tag, "_done"},  done,          0);
      chk({tag, "_board"}, board_out,     0);
      chk({tag, "_lines"}, lines_cleared, 0);
      chk({tag, "_error"}, error,         0);
      chk({tag, "_gover"}, game_over,     0);
      chk({tag, "_total"}, total_lines,   0);
      chk({tag, "_tot2"},  total_lines2,  0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int snap;
      restart    = 1'b1;
      start      = 1'b0;
      board_in   = '0;
      curr_piece = 2'b00;
      gover_m    = 1'b0;
      total_m    = 0;
      total2_m   = 0;
      repeat (2) @(negedge clka);
      chk_zero("reset");
      restart = 1'b0;
      @(negedge clka);

      issue(32'hF000_0000, 2'b00, 1); wait_done();
      chk("t1_board", board_out, 32'h0000_0002);

      issue(32'hFF30_0000, 2'b10, 1); wait_done();
      chk("t2_board", board_out, 32'h3000_0066);
      chk("t2_total", total_lines, 3);

      issue(32'hF1F8_0000, 2'b01, 1); wait_done();
      chk("t3_board", board_out, 32'h1800_0006);

      issue(32'h0000_0020, 2'b11, 1); wait_done();
      chk("coll_board", board_out, 32'h0000_0062);
      chk("coll_error", error, 1);

      issue(32'h0000_0000, 2'b00, 1); wait_done();
      chk("sticky_error", error, 0);
      chk("sticky_gover", game_over, 1);

      issue(32'hFFFF_FFFF, 2'b10, 1); wait_done();
      chk("full_lines", lines_cleared, ROWS);
      chk("full_board", board_out, 32'h0000_0066);

      // start pulsed while busy must be dropped
      issue(32'h00F0_1234, 2'b01, 1);
      repeat (3) @(negedge clka);
      issue(32'hFFFF_FFFF, 2'b00, 0);
      wait_done();
      repeat (2) @(negedge clka);
      snap = done_cnt;
      repeat (15) @(negedge clka);
      chk("single_done", done_cnt, snap);
      chk("idle_busy", busy, 0);

      // back-to-back: start presented in the done cycle
      issue(32'h8421_0F00, 2'b11, 1); wait_done();
      issue(32'h0F0F_0F0F, 2'b01, 1); wait_done();

      // restart in the middle of SCAN
      issue(32'hF0F0_F0F0, 2'b10, 1);
      repeat (3) @(negedge clka);
      restart = 1'b1;
      @(negedge clka);
      chk_zero("midscan");
      restart = 1'b0;
      sb.delete();
      gover_m  = 1'b0;
      total_m  = 0;
      total2_m = 0;
      repeat (2) @(negedge clka);
      snap = done_cnt;
      repeat (15) @(negedge clka);
      chk("abort_no_done", done_cnt, snap);

      // saturation on the 2-bit instance
      issue(32'hFF00_0000, 2'b00, 1); wait_done();
      chk("sat_1", total_lines2, 2);
      issue(32'hFF00_0000, 2'b00, 1); wait_done();
      chk("sat_2", total_lines2, 3);
      issue(32'hFF00_0000, 2'b00, 1); wait_done();
      chk("sat_3", total_lines2, 3);
      chk("nosat_3", total_lines, 6);

      repeat (2) @(negedge clka);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
